// File: rtl/jk_cmd_pkg.sv
// rtl/jk_cmd_pkg.sv - shared JK command encoding for the encoder and the JK flop bank
// Purpose: 2-bit per-lane JK command type ({j,k}) and the lane encoding rule.
// Ports: none (package).
package jk_cmd_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_e;

  // A lane that already matches its target holds; otherwise it either toggles
  // or is forced to the target value, depending on the caller's preference.
  function automatic jk_cmd_e jk_encode_lane(input logic target,
                                             input logic shadow,
                                             input logic toggle_pref);
    jk_cmd_e cmd;
    if (target == shadow) begin
      cmd = JK_HOLD;
    end else if (toggle_pref) begin
      cmd = JK_TOGGLE;
    end else if (target) begin
      cmd = JK_SET;
    end else begin
      cmd = JK_RESET;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with flush, no bypass
// Purpose: DEPTH-entry word queue; full/empty derived from wrap-bit pointers.
// Ports:
//   clk, reset (sync, active-low), flush (sync, active-high, drops all entries)
//   push/wdata : write side, ignored when full or flushing
//   pop/rdata  : read side, rdata is the current head, pop ignored when empty or flushing
//   full/empty : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only observable between the pointers.
  always_ff @(posedge clk) begin
    if (do_push && reset) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/jk_cmd_encoder.sv
// rtl/jk_cmd_encoder.sv - turns a stream of target flop states into per-lane JK commands
// Purpose: queue targets, encode each against a shadow model of the flop bank,
//          present one registered command per cycle with valid/ready flow control.
// Ports:
//   clk, reset (sync, active-low), flush (sync, active-high)
//   in_valid/in_ready/in_target : target word input
//   toggle_pref                 : changed lanes use TOGGLE (1) or SET/RESET (0)
//   cmd_valid/cmd_ready         : command handshake
//   cmd_j/cmd_k/cmd_nop         : per-lane J and K, all-HOLD indicator
//   shadow_q                    : modelled flop state after all encoded commands
module jk_cmd_encoder
  import jk_cmd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_target,
  input  logic             toggle_pref,
  input  logic             flush,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [WIDTH-1:0] cmd_j,
  output logic [WIDTH-1:0] cmd_k,
  output logic             cmd_nop,
  output logic [WIDTH-1:0] shadow_q
);

  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             load;

  logic             cmd_valid_q, cmd_valid_d;
  logic [WIDTH-1:0] cmd_j_q, cmd_j_d;
  logic [WIDTH-1:0] cmd_k_q, cmd_k_d;
  logic             cmd_nop_q, cmd_nop_d;
  logic [WIDTH-1:0] shadow_d;
  logic [WIDTH-1:0] enc_j;
  logic [WIDTH-1:0] enc_k;

  assign in_ready = !fifo_full;

  // The output register refills whenever it is empty or being drained this
  // cycle; flush takes precedence so nothing is popped on a flush edge.
  assign load = !fifo_empty && (!cmd_valid_q || cmd_ready) && !flush;

  sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (in_valid),
    .wdata (in_target),
    .pop   (load),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    logic [1:0] lane;
    enc_j = '0;
    enc_k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lane     = jk_encode_lane(fifo_rdata[i], shadow_q[i], toggle_pref);
      enc_j[i] = lane[1];
      enc_k[i] = lane[0];
    end
  end

  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_j_d     = cmd_j_q;
    cmd_k_d     = cmd_k_q;
    cmd_nop_d   = cmd_nop_q;
    shadow_d    = shadow_q;
    if (flush) begin
      cmd_valid_d = 1'b0;
    end else if (load) begin
      cmd_valid_d = 1'b1;
      cmd_j_d     = enc_j;
      cmd_k_d     = enc_k;
      cmd_nop_d   = ((enc_j | enc_k) == '0);
      shadow_d    = fifo_rdata;
    end else if (cmd_ready) begin
      cmd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cmd_valid_q <= 1'b0;
      cmd_j_q     <= '0;
      cmd_k_q     <= '0;
      cmd_nop_q   <= 1'b0;
      shadow_q    <= '0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_j_q     <= cmd_j_d;
      cmd_k_q     <= cmd_k_d;
      cmd_nop_q   <= cmd_nop_d;
      shadow_q    <= shadow_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_j     = cmd_j_q;
  assign cmd_k     = cmd_k_q;
  assign cmd_nop   = cmd_nop_q;

endmodule

// File: tb/tb_jk_cmd_encoder.sv
// tb/tb_jk_cmd_encoder.sv - scoreboard bench for jk_cmd_encoder
module tb_jk_cmd_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_target;
  logic       toggle_pref;
  logic       flush;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_j;
  logic [7:0] cmd_k;
  logic       cmd_nop;
  logic [7:0] shadow_q;

  always #5 clk = ~clk;

  jk_cmd_encoder #(.WIDTH(8), .DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_target   (in_target),
    .toggle_pref (toggle_pref),
    .flush       (flush),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_j       (cmd_j),
    .cmd_k       (cmd_k),
    .cmd_nop     (cmd_nop),
    .shadow_q    (shadow_q)
  );

  typedef struct packed {
    logic [7:0] j;
    logic [7:0] k;
    logic       nop;
    logic [7:0] sh;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cmd(input logic [7:0] j, input logic [7:0] k,
                            input logic nop, input logic [7:0] sh);
    exp_t e;
    e.j   = j;
    e.k   = k;
    e.nop = nop;
    e.sh  = sh;
    sb.push_back(e);
  endtask

  task automatic push(input logic [7:0] d);
    logic done;
    done      = 1'b0;
    in_valid  = 1'b1;
    in_target = d;
    for (int i = 0; i < 50 && !done; i++) begin
      done = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: got in_ready=0 for 50 cycles expected acceptance of %0h", d);
    end
  endtask

  // Pops the scoreboard on every accepted command and checks that a stalled
  // command does not change.
  task automatic monitor();
    exp_t        e;
    logic        stalled;
    logic [16:0] held;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (reset && cmd_valid && stalled) begin
        chk("stall_hold", 32'({cmd_j, cmd_k, cmd_nop}), 32'(held));
      end
      if (reset && cmd_valid && cmd_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_cmd: got j=%0h k=%0h expected no command", cmd_j, cmd_k);
        end else begin
          e = sb.pop_front();
          chk("cmd_j", 32'(cmd_j), 32'(e.j));
          chk("cmd_k", 32'(cmd_k), 32'(e.k));
          chk("cmd_nop", 32'(cmd_nop), 32'(e.nop));
          chk("cmd_shadow", 32'(shadow_q), 32'(e.sh));
        end
      end
      stalled = reset && cmd_valid && !cmd_ready && !flush;
      held    = {cmd_j, cmd_k, cmd_nop};
    end
  endtask

  initial begin
    int cnt;
    reset       = 1'b0;
    in_valid    = 1'b0;
    in_target   = 8'h00;
    toggle_pref = 1'b0;
    flush       = 1'b0;
    cmd_ready   = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) tick();
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_cmd_j", 32'(cmd_j), 32'd0);
    chk("rst_cmd_k", 32'(cmd_k), 32'd0);
    chk("rst_cmd_nop", 32'(cmd_nop), 32'd0);
    chk("rst_shadow", 32'(shadow_q), 32'd0);
    reset = 1'b1;
    tick();
    chk("in_ready_post_reset", 32'(in_ready), 32'd1);

    // SET/RESET encoding from an all-zero shadow, with latency check.
    cmd_ready = 1'b1;
    expect_cmd(8'hA5, 8'h00, 1'b0, 8'hA5);
    push(8'hA5);
    chk("latency_e0", 32'(cmd_valid), 32'd0);
    tick();
    chk("latency_e1", 32'(cmd_valid), 32'd1);
    repeat (3) tick();

    // Every lane differs and toggling is preferred.
    toggle_pref = 1'b1;
    expect_cmd(8'hFF, 8'hFF, 1'b0, 8'h5A);
    push(8'h5A);
    repeat (3) tick();

    // Same target again: all lanes hold.
    expect_cmd(8'h00, 8'h00, 1'b1, 8'h5A);
    push(8'h5A);
    repeat (3) tick();
    toggle_pref = 1'b0;

    // Fill with downstream stalled: output register plus DEPTH entries.
    cmd_ready = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      if (!in_ready) break;
      in_valid  = 1'b1;
      in_target = 8'(i);
      tick();
      cnt++;
    end
    in_valid = 1'b0;
    chk("fill_count", 32'(cnt), 32'd5);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_shadow", 32'(shadow_q), 32'h01);
    expect_cmd(8'h01, 8'h5A, 1'b0, 8'h01);
    expect_cmd(8'h02, 8'h01, 1'b0, 8'h02);
    expect_cmd(8'h01, 8'h00, 1'b0, 8'h03);
    expect_cmd(8'h04, 8'h03, 1'b0, 8'h04);
    expect_cmd(8'h01, 8'h00, 1'b0, 8'h05);
    cmd_ready = 1'b1;
    repeat (4) tick();
    chk("drain_4_valid", 32'(cmd_valid), 32'd1);
    tick();
    chk("drain_5_valid", 32'(cmd_valid), 32'd0);
    chk("drain_shadow", 32'(shadow_q), 32'h05);

    // Flush with one command presented and three queued.
    cmd_ready = 1'b0;
    push(8'h10);
    push(8'h11);
    push(8'h12);
    push(8'h13);
    tick();
    chk("pre_flush_valid", 32'(cmd_valid), 32'd1);
    chk("pre_flush_shadow", 32'(shadow_q), 32'h10);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_target = 8'h77;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 32'(cmd_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_shadow", 32'(shadow_q), 32'h10);
    repeat (2) tick();
    chk("flush_dropped", 32'(cmd_valid), 32'd0);

    // Reset while stalled with a full FIFO.
    push(8'h20);
    push(8'h21);
    push(8'h22);
    push(8'h23);
    push(8'h24);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_valid", 32'(cmd_valid), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_valid", 32'(cmd_valid), 32'd0);
    chk("midrst_j", 32'(cmd_j), 32'd0);
    chk("midrst_k", 32'(cmd_k), 32'd0);
    chk("midrst_nop", 32'(cmd_nop), 32'd0);
    chk("midrst_shadow", 32'(shadow_q), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    cmd_ready = 1'b1;
    expect_cmd(8'h01, 8'h00, 1'b0, 8'h01);
    push(8'h01);
    repeat (4) tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
